// File: rtl/pa_sysmap_pkg.sv
// Shared definitions for the sysmap bus-interface controller: FSM encoding,
// data width and the control-register index offset.
package pa_sysmap_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] ST_SAMPLE = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_EXEC   = 2'd2;
    localparam logic [1:0] ST_RSP    = 2'd3;

    // Each region owns two indices (base, flag); the control register follows them.
    localparam int CTRL_IDX_MUL = 2;

    function automatic int ctrl_idx(input int region_num);
        return CTRL_IDX_MUL * region_num;
    endfunction

endpackage

// File: rtl/pa_sysmap_busif_dec.sv
// Combinational request decode: index to one-hot strobes, read-value select,
// control-register hit and invalid (out-of-range or locked write) detection.
module pa_sysmap_busif_dec
    import pa_sysmap_pkg::*;
#(
    parameter int REGION_NUM = 8,
    parameter int IDX_W      = 5
) (
    input  logic [IDX_W-1:0]             idx_i,
    input  logic                         wen_i,
    input  logic                         lock_i,
    input  logic [DATA_W*REGION_NUM-1:0] base_value_i,
    input  logic [DATA_W*REGION_NUM-1:0] flg_value_i,
    output logic [REGION_NUM-1:0]        base_updt_o,
    output logic [REGION_NUM-1:0]        flg_updt_o,
    output logic                         ctrl_sel_o,
    output logic                         invalid_o,
    output logic [DATA_W-1:0]            rd_value_o
);

    localparam int RW = $clog2(REGION_NUM);
    localparam logic [IDX_W-1:0] CTRL_IDX = IDX_W'(ctrl_idx(REGION_NUM));

    logic          in_region;
    logic [RW-1:0] region;

    assign in_region = (idx_i < CTRL_IDX);
    assign region    = idx_i[RW:1];

    always_comb begin
        base_updt_o = '0;
        flg_updt_o  = '0;
        rd_value_o  = '0;
        ctrl_sel_o  = (idx_i == CTRL_IDX);
        invalid_o   = (idx_i > CTRL_IDX) || (wen_i && lock_i && in_region);
        if (in_region) begin
            rd_value_o = idx_i[0] ? flg_value_i[int'(region)*DATA_W +: DATA_W]
                                  : base_value_i[int'(region)*DATA_W +: DATA_W];
            if (wen_i && !lock_i) begin
                if (idx_i[0]) flg_updt_o[region]  = 1'b1;
                else          base_updt_o[region] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pa_sysmap_busif_ctrl.sv
// Sysmap region register bank sequencer: post-reset sample pulse, then
// fixed-latency single-beat register access. Optional lock: PA_SYSMAP_LOCK_EN.
module pa_sysmap_busif_ctrl
    import pa_sysmap_pkg::*;
#(
    parameter int REGION_NUM = 8,
    parameter int IDX_W      = 5
) (
    input  logic                         sysmap_clk,
    input  logic                         cpurst,
    input  logic                         ctrl_req_vld,
    output logic                         ctrl_req_ready,
    input  logic                         ctrl_req_wen,
    input  logic [IDX_W-1:0]             ctrl_req_idx,
    input  logic [DATA_W-1:0]            ctrl_req_wdata,
    output logic                         ctrl_ack,
    output logic                         ctrl_err,
    output logic [DATA_W-1:0]            ctrl_rdata,
    output logic                         ifu_sysmap_rst_sample,
    output logic [REGION_NUM-1:0]        busif_base_addr_updt,
    output logic [REGION_NUM-1:0]        busif_flg_updt,
    output logic [DATA_W-1:0]            busif_wdata,
    input  logic [DATA_W*REGION_NUM-1:0] busif_base_addr_value,
    input  logic [DATA_W*REGION_NUM-1:0] busif_flg_value
);

    logic [1:0]            state_q, state_d;
    logic                  sample_q;
    logic                  wen_q, pend_err_q, ctrl_q;
    logic [IDX_W-1:0]      idx_q;
    logic [REGION_NUM-1:0] base_updt_q, flg_updt_q;
    logic [DATA_W-1:0]     wdata_q, rdata_q;
    logic                  ack_q, err_q;
    logic                  lock;
    logic                  accept;

    logic [IDX_W-1:0]      dec_idx;
    logic                  dec_wen;
    logic [REGION_NUM-1:0] dec_base, dec_flg;
    logic                  dec_ctrl, dec_invalid;
    logic [DATA_W-1:0]     dec_rd_value;

    // State register
    always_ff @(posedge sysmap_clk or posedge cpurst) begin
        if (cpurst) state_q <= ST_SAMPLE;
        else        state_q <= state_d;
    end

    // Next-state logic; SAMPLE holds one extra cycle so the pulse is seen while ready is low
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SAMPLE: if (sample_q)     state_d = ST_IDLE;
            ST_IDLE:   if (ctrl_req_vld) state_d = ST_EXEC;
            ST_EXEC:                     state_d = ST_RSP;
            default:                     state_d = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        ctrl_req_ready = (state_q == ST_IDLE);
    end

    assign accept = (state_q == ST_IDLE) && ctrl_req_vld;

    // Decode the live request in IDLE, the latched one afterwards (read select in EXEC)
    assign dec_idx = (state_q == ST_IDLE) ? ctrl_req_idx : idx_q;
    assign dec_wen = (state_q == ST_IDLE) ? ctrl_req_wen : wen_q;

    pa_sysmap_busif_dec #(
        .REGION_NUM (REGION_NUM),
        .IDX_W      (IDX_W)
    ) u_dec (
        .idx_i        (dec_idx),
        .wen_i        (dec_wen),
        .lock_i       (lock),
        .base_value_i (busif_base_addr_value),
        .flg_value_i  (busif_flg_value),
        .base_updt_o  (dec_base),
        .flg_updt_o   (dec_flg),
        .ctrl_sel_o   (dec_ctrl),
        .invalid_o    (dec_invalid),
        .rd_value_o   (dec_rd_value)
    );

    always_ff @(posedge sysmap_clk or posedge cpurst) begin
        if (cpurst) begin
            sample_q    <= 1'b0;
            wen_q       <= 1'b0;
            idx_q       <= '0;
            pend_err_q  <= 1'b0;
            ctrl_q      <= 1'b0;
            base_updt_q <= '0;
            flg_updt_q  <= '0;
            wdata_q     <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            sample_q    <= (state_q == ST_SAMPLE) && !sample_q;
            base_updt_q <= '0;
            flg_updt_q  <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            if (accept) begin
                wen_q       <= ctrl_req_wen;
                idx_q       <= ctrl_req_idx;
                pend_err_q  <= dec_invalid;
                ctrl_q      <= dec_ctrl;
                base_updt_q <= dec_base;
                flg_updt_q  <= dec_flg;
                if (ctrl_req_wen) wdata_q <= ctrl_req_wdata;
            end
            if (state_q == ST_EXEC) begin
                ack_q <= 1'b1;
                err_q <= pend_err_q;
                if (!pend_err_q && !wen_q)
                    rdata_q <= ctrl_q ? {{(DATA_W-1){1'b0}}, lock} : dec_rd_value;
            end
        end
    end

`ifdef PA_SYSMAP_LOCK_EN
    logic lock_q;

    always_ff @(posedge sysmap_clk or posedge cpurst) begin
        if (cpurst)
            lock_q <= 1'b0;
        else if (accept && ctrl_req_wen && dec_ctrl && ctrl_req_wdata[0])
            lock_q <= 1'b1;
    end

    assign lock = lock_q;
`else
    assign lock = 1'b0;
`endif

    assign ifu_sysmap_rst_sample = sample_q;
    assign busif_base_addr_updt  = base_updt_q;
    assign busif_flg_updt        = flg_updt_q;
    assign busif_wdata           = wdata_q;
    assign ctrl_ack              = ack_q;
    assign ctrl_err              = err_q;
    assign ctrl_rdata            = rdata_q;

endmodule

// File: tb/tb_pa_sysmap_busif_ctrl.sv
// Directed bench for pa_sysmap_busif_ctrl; expectations follow PA_SYSMAP_LOCK_EN.
module tb_pa_sysmap_busif_ctrl;

    localparam int RN = 8;
    localparam int IW = 5;

    logic            sysmap_clk = 1'b0;
    logic            cpurst;
    logic            ctrl_req_vld;
    logic            ctrl_req_ready;
    logic            ctrl_req_wen;
    logic [IW-1:0]   ctrl_req_idx;
    logic [31:0]     ctrl_req_wdata;
    logic            ctrl_ack;
    logic            ctrl_err;
    logic [31:0]     ctrl_rdata;
    logic            ifu_sysmap_rst_sample;
    logic [RN-1:0]   busif_base_addr_updt;
    logic [RN-1:0]   busif_flg_updt;
    logic [31:0]     busif_wdata;
    logic [32*RN-1:0] busif_base_addr_value;
    logic [32*RN-1:0] busif_flg_value;

    int vectors = 0;
    int miscompares = 0;

    pa_sysmap_busif_ctrl #(.REGION_NUM(RN), .IDX_W(IW)) dut (
        .sysmap_clk            (sysmap_clk),
        .cpurst                (cpurst),
        .ctrl_req_vld          (ctrl_req_vld),
        .ctrl_req_ready        (ctrl_req_ready),
        .ctrl_req_wen          (ctrl_req_wen),
        .ctrl_req_idx          (ctrl_req_idx),
        .ctrl_req_wdata        (ctrl_req_wdata),
        .ctrl_ack              (ctrl_ack),
        .ctrl_err              (ctrl_err),
        .ctrl_rdata            (ctrl_rdata),
        .ifu_sysmap_rst_sample (ifu_sysmap_rst_sample),
        .busif_base_addr_updt  (busif_base_addr_updt),
        .busif_flg_updt        (busif_flg_updt),
        .busif_wdata           (busif_wdata),
        .busif_base_addr_value (busif_base_addr_value),
        .busif_flg_value       (busif_flg_value)
    );

    always #5 sysmap_clk = ~sysmap_clk;

    task automatic step();
        @(posedge sysmap_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access: drive in IDLE, check strobes in EXEC, response in RSP, ready after.
    task automatic req(input string tag, input logic wen, input logic [IW-1:0] idx,
                       input logic [31:0] wdata, input logic [RN-1:0] exp_base,
                       input logic [RN-1:0] exp_flg, input logic exp_err,
                       input logic [31:0] exp_rdata);
        chk({tag, "_ready"}, 32'(ctrl_req_ready), 32'd1);
        ctrl_req_vld   = 1'b1;
        ctrl_req_wen   = wen;
        ctrl_req_idx   = idx;
        ctrl_req_wdata = wdata;
        step();
        ctrl_req_vld   = 1'b0;
        ctrl_req_wdata = 32'hDEAD_BEEF;
        chk({tag, "_base_updt"}, 32'(busif_base_addr_updt), 32'(exp_base));
        chk({tag, "_flg_updt"}, 32'(busif_flg_updt), 32'(exp_flg));
        chk({tag, "_exec_ack"}, 32'(ctrl_ack), 32'd0);
        if (exp_base != '0 || exp_flg != '0) chk({tag, "_wdata"}, busif_wdata, wdata);
        step();
        chk({tag, "_ack"}, 32'(ctrl_ack), 32'd1);
        chk({tag, "_err"}, 32'(ctrl_err), 32'(exp_err));
        chk({tag, "_rdata"}, ctrl_rdata, exp_rdata);
        chk({tag, "_rsp_strobe"}, 32'(busif_base_addr_updt | busif_flg_updt), 32'd0);
        step();
        chk({tag, "_ack_done"}, 32'(ctrl_ack), 32'd0);
    endtask

    task automatic release_and_sample(input string tag);
        cpurst = 1'b0;
        chk({tag, "_c0_sample"}, 32'(ifu_sysmap_rst_sample), 32'd0);
        chk({tag, "_c0_ready"}, 32'(ctrl_req_ready), 32'd0);
        step();
        chk({tag, "_c1_sample"}, 32'(ifu_sysmap_rst_sample), 32'd1);
        chk({tag, "_c1_ready"}, 32'(ctrl_req_ready), 32'd0);
        step();
        chk({tag, "_c2_sample"}, 32'(ifu_sysmap_rst_sample), 32'd0);
        chk({tag, "_c2_ready"}, 32'(ctrl_req_ready), 32'd1);
    endtask

    initial begin
        logic lock_en;
`ifdef PA_SYSMAP_LOCK_EN
        lock_en = 1'b1;
`else
        lock_en = 1'b0;
`endif
        cpurst         = 1'b1;
        ctrl_req_vld   = 1'b0;
        ctrl_req_wen   = 1'b0;
        ctrl_req_idx   = '0;
        ctrl_req_wdata = '0;
        for (int r = 0; r < RN; r++) begin
            busif_base_addr_value[32*r +: 32] = 32'h1000_0000 + 32'(r);
            busif_flg_value[32*r +: 32]       = 32'h2000_0000 + 32'(r);
        end
        busif_base_addr_value[95:64] = 32'h000A_BCDE;

        repeat (3) step();
        chk("rst_ready", 32'(ctrl_req_ready), 32'd0);
        chk("rst_ack", 32'(ctrl_ack), 32'd0);
        chk("rst_err", 32'(ctrl_err), 32'd0);
        chk("rst_rdata", ctrl_rdata, 32'd0);
        chk("rst_strobes", 32'(busif_base_addr_updt | busif_flg_updt), 32'd0);
        chk("rst_wdata", busif_wdata, 32'd0);
        chk("rst_sample", 32'(ifu_sysmap_rst_sample), 32'd0);

        release_and_sample("boot");

        req("wr_idx5", 1'b1, 5'd5, 32'h0000_001C, 8'h00, 8'h04, 1'b0, 32'd0);
        req("rd_idx4", 1'b0, 5'd4, 32'd0, 8'h00, 8'h00, 1'b0, 32'h000A_BCDE);
        req("rd_idx7", 1'b0, 5'd7, 32'd0, 8'h00, 8'h00, 1'b0, 32'h2000_0003);
        req("rd_idx15", 1'b0, 5'd15, 32'd0, 8'h00, 8'h00, 1'b0, 32'h2000_0007);
        req("wr_idx17", 1'b1, 5'd17, 32'h1234_5678, 8'h00, 8'h00, 1'b1, 32'd0);
        req("rd_idx31", 1'b0, 5'd31, 32'd0, 8'h00, 8'h00, 1'b1, 32'd0);
        req("wr_idx1", 1'b1, 5'd1, 32'hA5A5_0001, 8'h00, 8'h01, 1'b0, 32'd0);
        req("wr_idx14", 1'b1, 5'd14, 32'h8000_4000, 8'h80, 8'h00, 1'b0, 32'd0);
        req("rd_ctrl0", 1'b0, 5'd16, 32'd0, 8'h00, 8'h00, 1'b0, 32'd0);
        req("wr_ctrl_0", 1'b1, 5'd16, 32'hFFFF_FFFE, 8'h00, 8'h00, 1'b0, 32'd0);
        req("rd_ctrl1", 1'b0, 5'd16, 32'd0, 8'h00, 8'h00, 1'b0, 32'd0);
        req("wr_ctrl_1", 1'b1, 5'd16, 32'h0000_0001, 8'h00, 8'h00, 1'b0, 32'd0);
        if (lock_en) begin
            req("wr_idx0_locked", 1'b1, 5'd0, 32'h0000_0F00, 8'h00, 8'h00, 1'b1, 32'd0);
            req("rd_ctrl_locked", 1'b0, 5'd16, 32'd0, 8'h00, 8'h00, 1'b0, 32'd1);
        end else begin
            req("wr_idx0_nolock", 1'b1, 5'd0, 32'h0000_0F00, 8'h01, 8'h00, 1'b0, 32'd0);
            req("rd_ctrl_nolock", 1'b0, 5'd16, 32'd0, 8'h00, 8'h00, 1'b0, 32'd0);
        end
        req("rd_idx4_post", 1'b0, 5'd4, 32'd0, 8'h00, 8'h00, 1'b0, 32'h000A_BCDE);

        // Reset in the EXEC cycle of a write aborts it.
        ctrl_req_vld   = 1'b1;
        ctrl_req_wen   = 1'b1;
        ctrl_req_idx   = 5'd3;
        ctrl_req_wdata = 32'h0000_0077;
        step();
        ctrl_req_vld = 1'b0;
        if (lock_en) chk("abort_exec_strobe", 32'(busif_flg_updt), 32'd0);
        else         chk("abort_exec_strobe", 32'(busif_flg_updt), 32'h02);
        cpurst = 1'b1;
        #1;
        chk("abort_strobe", 32'(busif_base_addr_updt | busif_flg_updt), 32'd0);
        chk("abort_ready", 32'(ctrl_req_ready), 32'd0);
        step();
        chk("abort_ack", 32'(ctrl_ack), 32'd0);
        step();
        chk("abort_ack2", 32'(ctrl_ack), 32'd0);
        release_and_sample("rerst");
        req("rd_ctrl_cleared", 1'b0, 5'd16, 32'd0, 8'h00, 8'h00, 1'b0, 32'd0);
        req("wr_idx0_unlocked", 1'b1, 5'd0, 32'h0000_0123, 8'h01, 8'h00, 1'b0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
